// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: data width, address default,
// FSM state encoding and the request address range check.
package mem_responder_pkg;

    localparam int DATA_W         = 32;
    localparam int ADDR_W_DEFAULT = 9;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when the full bus address lies inside the 2^aw word array.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr, input int aw);
        return (addr >> aw) == {DATA_W{1'b0}};
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read.
// The array itself has no reset so its contents survive clr.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Read register holds its value until the next enabled read.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one read or write in IDLE, waits
// LATENCY+1 cycles, completes in DONE; illegal requests strobe err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              is_wr_d, is_wr_q;
    logic              done_d, done_q;
    logic              busy_d, busy_q;
    logic              err_d, err_q;
    logic              mem_we_s;
    logic              mem_re_s;
    logic              req_any_s;
    logic              req_legal_s;

    assign req_any_s   = read | write;
    assign req_legal_s = (read ^ write) & addr_in_range(address, ADDR_W);

    // Next-state, counter, request latch and memory strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s && req_legal_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_C;
                    addr_d  = address[ADDR_W-1:0];
                    wdata_d = data_in;
                    is_wr_d = write;
                end else if (req_any_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The memory access happens on the same edge that enters DONE.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    mem_we_s = is_wr_q;
                    mem_re_s = ~is_wr_q;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            is_wr_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (clr),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (data_out)
    );

    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning word-address width (depth 2^ADDR_W = 512 words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait-state cycles inserted before each access completes (legal range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port clr, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port read, input, 1, read request from the datapath (level, sampled in IDLE).
REQ-006 SHALL have port write, input, 1, write request from the datapath (level, sampled in IDLE).
REQ-007 SHALL have port address, input, 32, the MAR value.
REQ-008 SHALL have port data_in, input, 32, the MDR value to be written.
REQ-009 SHALL have port data_out, output, 32, read data delivered toward MDR.
REQ-010 SHALL have port done, output, 1, one-cycle completion strobe.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port err, output, 1, one-cycle strobe for a rejected request.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE; IDLE -> WAIT on an accepted request; WAIT -> DONE when the wait counter expires; DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL accept a request only in IDLE, and only when exactly one of read/write is high and address < 2^ADDR_W.
REQ-015 SHALL latch address[ADDR_W-1:0], data_in and the operation type on the accepting edge; later changes of the inputs SHALL NOT affect the access in progress.
REQ-016 SHALL load the wait counter with LATENCY on acceptance, decrement it once per cycle in WAIT, and leave WAIT on the edge where the counter equals 0; with LATENCY=0 the WAIT state lasts exactly one cycle.
REQ-017 SHALL assert done during the cycle after LATENCY+1 rising edges from the accepting edge, for exactly one cycle (the DONE state).
REQ-018 For a write, the memory word SHALL be updated on the edge that enters DONE, and data_out SHALL be left unchanged.
REQ-019 For a read, data_out SHALL be updated on the edge that enters DONE and held until the next completed read.
REQ-020 SHALL ignore read/write while busy is high, including during the DONE cycle; the next request can be accepted no earlier than the edge ending the DONE cycle, giving a minimum spacing of LATENCY+3 cycles between acceptances.
REQ-021 SHALL pulse err for one cycle, without entering WAIT and without touching memory or data_out, when read and write are both high in IDLE, or when a read/write request in IDLE carries address >= 2^ADDR_W.
REQ-022 SHALL hold err high for one cycle per sampled edge while the illegal request persists in IDLE.
REQ-023 SHALL NOT initialise memory contents; contents are undefined until written.

Reset
REQ-024 On clr low, the block SHALL immediately enter IDLE with done=0, busy=0, err=0, data_out=0 and the wait counter at 0.
REQ-025 A reset asserted mid-access SHALL abort it; a write not yet committed SHALL NOT update memory.
REQ-026 Memory contents SHALL be retained across reset.

Structure
REQ-027 The state encoding and the data width constant (32) SHALL reside in the shared project package, together with the ADDR_W default.
REQ-028 The storage array SHALL be a sub-module named mem_array (synchronous write, registered read, single port); the FSM, counter and checks SHALL live in mem_responder.

Verification
REQ-029 Write 0xDEADBEEF to address 0x005 (LATENCY=2), then read 0x005 -> done is high exactly 3 cycles after each accepting edge; data_out = 0xDEADBEEF.
REQ-030 With LATENCY=0, write 0x00000001 to 0x1FF and read it back -> done appears 1 cycle after acceptance; data_out = 0x00000001; address wraps to no other location.
REQ-031 Raise read and write together in IDLE -> err=1 for one cycle, busy stays 0, and a later read of an earlier-written word returns its previous value.
REQ-032 Read at address 0x200 -> err pulses, no done; change address and data_in during WAIT of a valid write -> the originally latched values are written.
REQ-033 Assert clr during WAIT of a write of 0x12345678 to 0x010 that previously held 0xAAAAAAAA -> busy=0 immediately; a subsequent read returns 0xAAAAAAAA.
REQ-034 Hold read high continuously -> accepted reads are spaced LATENCY+3 cycles apart, with exactly one done per access.
